// File: rtl/etherparse_pkg.sv
// Shared definitions for the Ethernet parse/ingress path.
//   ingress_state_t  : frame FSM state of axis_ingress
//   TUSER_ERR_BIT    : tuser bit that carries the frame error flag
//   ETH64_MAX_BEATS  : longest legal frame in 64-bit beats
package etherparse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IN_FRAME,
    ST_DROP
  } ingress_state_t;

  localparam int unsigned TUSER_ERR_BIT   = 0;
  localparam int unsigned ETH64_MAX_BEATS = 190;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one skid register.
// Gives full throughput with every output and s_ready registered.
//   clk, rst          : clock, synchronous active-high reset
//   s_data/valid/ready: upstream handshake (s_ready == skid register empty)
//   m_data/valid/ready: downstream handshake
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             in_acc;
  logic             out_free;

  assign in_acc   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  // s_ready is low whenever the skid holds a beat, so an accept never
  // coincides with a skid drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      skid_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          m_data     <= skid_data;
          m_valid    <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          m_valid <= in_acc;
          if (in_acc) m_data <= s_data;
        end
      end else if (in_acc) begin
        skid_data  <= s_data;
        skid_valid <= 1'b1;
      end
      s_ready <= out_free || !(skid_valid || in_acc);
    end
  end

endmodule

// File: rtl/axis_ingress.sv
// AXI-stream ingress boundary. Registers the external stream through a
// skid buffer, truncates frames longer than MAX_BEATS (flagging the last
// delivered beat via tuser[0]) and keeps saturating frame/truncation counters.
//   clk, rst            : clock, synchronous active-high reset
//   s_t*                : external stream in
//   m_t*                : internal stream out
//   frame_count         : frames delivered (saturating)
//   trunc_count         : truncated frames delivered (saturating)
module axis_ingress
  import etherparse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MAX_BEATS  = ETH64_MAX_BEATS,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  trunc_count
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  // Payload carries a private truncation marker next to tlast so that an
  // upstream tuser error is never counted as a truncation.
  localparam int unsigned PW = DATA_WIDTH + USER_WIDTH + 2;

  ingress_state_t        state;
  logic [CW-1:0]         beat_cnt;
  logic                  in_acc;
  logic                  out_xfer;
  logic                  at_limit;
  logic                  trunc_now;
  logic                  enq_valid;
  logic                  enq_last;
  logic [USER_WIDTH-1:0] enq_user;
  logic [PW-1:0]         enq_payload;
  logic [PW-1:0]         m_payload;
  logic                  m_trunc;

  assign in_acc    = s_tvalid && s_tready;
  assign out_xfer  = m_tvalid && m_tready;
  assign at_limit  = (beat_cnt == CW'(MAX_BEATS - 1));
  assign trunc_now = (state == ST_IN_FRAME) && at_limit && !s_tlast;
  assign enq_valid = s_tvalid && (state != ST_DROP);
  assign enq_last  = s_tlast || trunc_now;

  always_comb begin
    enq_user = s_tuser;
    if (trunc_now) enq_user[TUSER_ERR_BIT] = 1'b1;
  end

  assign enq_payload = {trunc_now, enq_last, enq_user, s_tdata};
  assign {m_trunc, m_tlast, m_tuser, m_tdata} = m_payload;

  // In DROP the skid sees no valid, but s_tready still follows the skid, so
  // dropped beats are consumed whenever the skid has room.
  axis_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  (enq_payload),
    .s_valid (enq_valid),
    .s_ready (s_tready),
    .m_data  (m_payload),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      frame_count <= '0;
      trunc_count <= '0;
    end else begin
      if (in_acc) begin
        case (state)
          ST_IDLE: begin
            if (!s_tlast) begin
              state    <= ST_IN_FRAME;
              beat_cnt <= CW'(1);
            end
          end
          ST_IN_FRAME: begin
            if (s_tlast) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else if (at_limit) begin
              state <= ST_DROP;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
          ST_DROP: begin
            if (s_tlast) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end
          end
          default: begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
          end
        endcase
      end

      if (out_xfer && m_tlast) begin
        if (frame_count != '1) frame_count <= frame_count + CNT_WIDTH'(1);
        if (m_trunc && (trunc_count != '1)) trunc_count <= trunc_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_ingress.sv
// Self-checking bench for axis_ingress (MAX_BEATS=4, 4-bit counters).
module tb_axis_ingress;

  localparam int DW = 16;
  localparam int UW = 2;
  localparam int MB = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] trunc_count;

  axis_ingress #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .MAX_BEATS  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .frame_count (frame_count),
    .trunc_count (trunc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
    logic          tr;
  } beat_t;

  typedef struct {
    int unsigned len;
    int unsigned mode;
    int unsigned exp_beats;
    logic        exp_u0;
    int unsigned exp_tr;
  } vec_t;

  beat_t       exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_frames, exp_trunc;
  int unsigned mdl_idx;
  bit          mdl_drop;
  bit          acc_flag;
  int unsigned obs_beats;
  logic        obs_last_u0;
  bit          prev_stall;
  logic [DW+UW:0] pv_out;
  bit          chk_lat, chk_rdy, prev_acc;
  logic [DW-1:0] prev_acc_d;
  int unsigned cyc = 0;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic rdy(input int unsigned mode);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Frame rules applied to each accepted input beat.
  task automatic model_accept(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    if (mdl_drop) begin
      if (l) begin mdl_drop = 0; mdl_idx = 0; end
    end else begin
      mdl_idx++;
      if (l) begin
        exp_q.push_back('{d, u, 1'b1, 1'b0});
        mdl_idx = 0;
      end else if (mdl_idx == MB) begin
        exp_q.push_back('{d, u | UW'(1), 1'b1, 1'b1});
        mdl_drop = 1;
        mdl_idx  = 0;
      end else begin
        exp_q.push_back('{d, u, 1'b0, 1'b0});
      end
    end
  endtask

  // One clock cycle: outputs observed here are post-edge; inputs applied now
  // take effect at the next edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic [UW-1:0] u, input logic r);
    beat_t e;
    if (prev_stall) begin
      check("hold_valid", 64'(m_tvalid), 64'd1);
      check("hold_data", 64'({m_tdata, m_tuser, m_tlast}), 64'(pv_out));
    end
    if (chk_lat && prev_acc) begin
      check("lat_valid", 64'(m_tvalid), 64'd1);
      check("lat_data", 64'(m_tdata), 64'(prev_acc_d));
    end
    if (chk_rdy) check("sready_hi", 64'(s_tready), 64'd1);
    s_tvalid = v; s_tdata = d; s_tlast = l; s_tuser = u; m_tready = r;
    if (m_tvalid && m_tready) begin
      obs_beats++;
      if (m_tlast) obs_last_u0 = m_tuser[0];
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat", 64'({m_tdata, m_tuser, m_tlast}), 64'({e.d, e.u, e.l}));
        if (e.l) begin
          if (exp_frames < CMAX) exp_frames++;
          if (e.tr && exp_trunc < CMAX) exp_trunc++;
        end
      end
    end
    prev_stall = m_tvalid && !m_tready;
    pv_out     = {m_tdata, m_tuser, m_tlast};
    acc_flag   = s_tvalid && s_tready;
    prev_acc   = acc_flag;
    prev_acc_d = d;
    if (acc_flag) model_accept(d, u, l);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0; s_tdata = '0; m_tready = 1'b0;
    @(posedge clk); #1;
    check("rst_sready", 64'(s_tready), 64'd0);
    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    mdl_idx = 0; mdl_drop = 0; exp_frames = 0; exp_trunc = 0;
    prev_stall = 0; prev_acc = 0;
    @(posedge clk); #1;
    check("post_rst_sready", 64'(s_tready), 64'd1);
    check("post_rst_mvalid", 64'(m_tvalid), 64'd0);
    check("post_rst_frames", 64'(frame_count), 64'd0);
    check("post_rst_trunc", 64'(trunc_count), 64'd0);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u,
                           input int unsigned mode);
    int unsigned tries = 0;
    do begin
      step(1'b1, d, l, u, rdy(mode));
      tries++;
    end while (!acc_flag && tries < 100);
    if (!acc_flag) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  task automatic send_frame(input int unsigned fid, input int unsigned len,
                            input int unsigned mode, input bit rnd);
    for (int unsigned b = 0; b < len; b++) begin
      if (rnd) while ($urandom_range(0, 3) == 0) step(1'b0, '0, 1'b0, '0, rdy(mode));
      send_beat({fid[7:0], b[7:0]}, b == len - 1, rnd ? UW'($urandom) : '0, mode);
    end
  endtask

  task automatic drain();
    int unsigned tries = 0;
    s_tvalid = 1'b0;
    while (exp_q.size() > 0 && tries < 100) begin
      step(1'b0, '0, 1'b0, '0, 1'b1);
      tries++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_mvalid", 64'(m_tvalid), 64'd0);
    check("frame_count", 64'(frame_count), 64'(exp_frames));
    check("trunc_count", 64'(trunc_count), 64'(exp_trunc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tr0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tuser = '0; m_tready = 1'b0;
    chk_lat = 0; chk_rdy = 0;
    do_reset();

    // Back-to-back 4-beat frames at full rate.
    chk_lat = 1; chk_rdy = 1;
    send_frame(1, 4, 0, 0);
    send_frame(2, 4, 0, 0);
    chk_rdy = 0;
    drain();
    chk_lat = 0;
    check("t1_frames", 64'(frame_count), 64'd2);

    // Stall: one beat lands in skid, s_tready drops the next cycle.
    do_reset();
    step(1'b1, 16'h0300, 1'b0, '0, 1'b1);
    check("stall_acc0", 64'(acc_flag), 64'd1);
    step(1'b1, 16'h0301, 1'b0, '0, 1'b0);
    check("stall_acc1", 64'(acc_flag), 64'd1);
    check("stall_sready_low", 64'(s_tready), 64'd0);
    step(1'b1, 16'h0302, 1'b1, '0, 1'b0);
    check("stall_noacc", 64'(acc_flag), 64'd0);
    send_beat(16'h0302, 1'b1, '0, 0);
    drain();
    send_frame(4, 4, 1, 0);
    send_frame(5, 4, 1, 0);
    drain();
    check("t2_frames", 64'(frame_count), 64'd3);

    // Frame-length table against MAX_BEATS=4.
    tbl[0] = '{7, 0, 4, 1'b1, 1};
    tbl[1] = '{2, 0, 2, 1'b0, 0};
    tbl[2] = '{4, 1, 4, 1'b0, 0};
    tbl[3] = '{5, 2, 4, 1'b1, 1};
    tbl[4] = '{1, 1, 1, 1'b0, 0};
    tbl[5] = '{3, 2, 3, 1'b0, 0};
    do_reset();
    for (int unsigned i = 0; i < 6; i++) begin
      tr0 = trunc_count;
      obs_beats = 0; obs_last_u0 = 1'bx;
      send_frame(16 + i, tbl[i].len, tbl[i].mode, 0);
      drain();
      check("tbl_beats", 64'(obs_beats), 64'(tbl[i].exp_beats));
      check("tbl_last_u0", 64'(obs_last_u0), 64'(tbl[i].exp_u0));
      check("tbl_trunc_delta", 64'(trunc_count - CW'(tr0)), 64'(tbl[i].exp_tr));
      if (i == 1) begin
        check("tbl_trunc_after2", 64'(trunc_count), 64'd1);
        check("tbl_frames_after2", 64'(frame_count), 64'd2);
      end
    end

    // Ten single-beat frames on consecutive cycles.
    do_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h0A00 + i), 1'b1, '0, 1'b1);
      check("single_acc", 64'(acc_flag), 64'd1);
    end
    drain();
    check("single_frames", 64'(frame_count), 64'd10);

    // Reset mid-frame with the output stalled.
    send_beat(16'h0B00, 1'b0, '0, 0);
    step(1'b1, 16'h0B01, 1'b0, '0, 1'b0);
    check("midrst_acc2", 64'(acc_flag), 64'd1);
    step(1'b1, 16'h0B02, 1'b0, '0, 1'b0);
    do_reset();
    send_frame(12, 3, 0, 0);
    drain();
    check("midrst_frames", 64'(frame_count), 64'd1);

    // Counter saturation.
    do_reset();
    for (int unsigned i = 0; i < 18; i++) send_frame(32 + i, 5, 0, 0);
    drain();
    check("sat_frames", 64'(frame_count), 64'(CMAX));
    check("sat_trunc", 64'(trunc_count), 64'(CMAX));

    // Randomized traffic against the model.
    do_reset();
    for (int unsigned i = 0; i < 150; i++) send_frame(i, $urandom_range(1, 9), 2, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
